// File: rtl/inst_fetch_buf.sv
// Instruction fetch buffer: tracks one in-flight SRAM fetch and queues
// returned {address, instruction} pairs in a small circular FIFO so the
// decode stage can stall without losing fetched instructions.
module inst_fetch_buf #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] NOP_INST = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_i,
  input  logic        re_i,
  input  logic [31:0] inst_i,
  input  logic        jump_flag_i,
  input  logic        hold_flag_i,
  output logic        fetch_hold_o,
  output logic [31:0] hold_addr_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
  output logic        inst_valid_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          pend_valid_q, pend_valid_d;
  logic [31:0]   pend_addr_q, pend_addr_d;

  logic [31:0]   mem_addr_q [DEPTH];
  logic [31:0]   mem_inst_q [DEPTH];

  logic [CW:0]   occupancy;
  logic          accept;
  logic          push;
  logic          pop;

  // Occupancy counts the in-flight fetch so a new fetch is only accepted
  // when its returning data is guaranteed a free slot.
  assign occupancy    = {1'b0, count_q} + {{CW{1'b0}}, pend_valid_q};
  assign fetch_hold_o = ~jump_flag_i & (occupancy >= (CW+1)'(DEPTH));
  assign hold_addr_o  = pc_i;

  assign accept = re_i & ~fetch_hold_o & ~jump_flag_i;
  assign push   = pend_valid_q & ~jump_flag_i;
  assign pop    = inst_valid_o & ~hold_flag_i & ~jump_flag_i;

  assign inst_valid_o = (count_q != '0);
  assign inst_o       = inst_valid_o ? mem_inst_q[rd_ptr_q] : NOP_INST;
  assign inst_addr_o  = inst_valid_o ? mem_addr_q[rd_ptr_q] : 32'h0;

  // Next-state: a redirect flushes everything, otherwise push/pop bookkeeping.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    pend_valid_d = accept;
    pend_addr_d  = accept ? pc_i : pend_addr_q;
    if (jump_flag_i) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      count_d      = '0;
      pend_valid_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      pend_valid_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      pend_valid_q <= pend_valid_d;
      // Occupancy gating on fetch accept makes a push into a full FIFO impossible.
      assert (!(push && (count_q == CW'(DEPTH))));
    end
  end

  // Address of the in-flight fetch; meaningful only while pend_valid_q is set.
  always_ff @(posedge clk) begin
    pend_addr_q <= pend_addr_d;
  end

  // Entry storage; contents are qualified by count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr_q[wr_ptr_q] <= pend_addr_q;
      mem_inst_q[wr_ptr_q] <= inst_i;
    end
  end

endmodule

// File: tb/tb_inst_fetch_buf.sv
// Directed bench for inst_fetch_buf: streaming, fill under decode stall,
// jump flush, pointer wrap with toggling stall, and mid-operation reset.
module tb_inst_fetch_buf;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_i;
  logic        re_i;
  logic [31:0] inst_i;
  logic        jump_flag_i;
  logic        hold_flag_i;
  logic        fetch_hold_o;
  logic [31:0] hold_addr_o;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        inst_valid_o;

  int n_tests = 0;
  int n_fail  = 0;

  inst_fetch_buf #(.DEPTH(4), .NOP_INST(NOP)) dut (
    .clk          (clk),
    .rst          (rst),
    .pc_i         (pc_i),
    .re_i         (re_i),
    .inst_i       (inst_i),
    .jump_flag_i  (jump_flag_i),
    .hold_flag_i  (hold_flag_i),
    .fetch_hold_o (fetch_hold_o),
    .hold_addr_o  (hold_addr_o),
    .inst_o       (inst_o),
    .inst_addr_o  (inst_addr_o),
    .inst_valid_o (inst_valid_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [31:0] a);
    return 32'hA5000000 ^ a;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [31:0] a, input logic [31:0] d);
    chk({tag, "_valid"}, {31'h0, inst_valid_o}, {31'h0, v});
    chk({tag, "_addr"}, inst_addr_o, a);
    chk({tag, "_inst"}, inst_o, d);
  endtask

  task automatic cyc(input logic re, input logic [31:0] pc, input logic [31:0] inst,
                     input logic hold, input logic jmp);
    re_i        = re;
    pc_i        = pc;
    inst_i      = inst;
    hold_flag_i = hold;
    jump_flag_i = jmp;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int          n_acc;
    int          n_pop;
    logic        last_acc;
    logic [31:0] last_pc;
    logic        hold;
    logic        re;
    logic [31:0] pc;
    logic        fh;

    rst = 1'b1;
    cyc(0, 0, 0, 0, 0);
    tick;
    tick;
    rst = 1'b0;

    // reset state
    cyc(0, 0, 0, 0, 0);
    chk_out("rst", 0, 32'h0, NOP);
    chk("rst_fh", {31'h0, fetch_hold_o}, 32'h0);

    // streaming, two-cycle latency
    tick; cyc(1, 32'h0, 32'h0, 0, 0); chk_out("str_c0", 0, 32'h0, NOP);
    tick; cyc(1, 32'h4, 32'hA, 0, 0); chk_out("str_c1", 0, 32'h0, NOP);
    tick; cyc(1, 32'h8, 32'hB, 0, 0); chk_out("str_c2", 1, 32'h0, 32'hA);
    tick; cyc(0, 32'h0, 32'hC, 0, 0); chk_out("str_c3", 1, 32'h4, 32'hB);
    tick; cyc(0, 32'h0, 32'h0, 0, 0); chk_out("str_c4", 1, 32'h8, 32'hC);
    tick; cyc(0, 32'h0, 32'h0, 0, 0); chk_out("str_c5", 0, 32'h0, NOP);

    // fill under decode stall
    tick; cyc(1, 32'h100, 32'h0, 1, 0);
    tick; cyc(1, 32'h104, mk(32'h100), 1, 0);
    tick; cyc(1, 32'h108, mk(32'h104), 1, 0);
    tick; cyc(1, 32'h10C, mk(32'h108), 1, 0);
    chk("fill_fh_open", {31'h0, fetch_hold_o}, 32'h0);
    tick; cyc(1, 32'h110, mk(32'h10C), 1, 0);
    chk("fill_fh_pend", {31'h0, fetch_hold_o}, 32'h1);
    chk("fill_hold_addr", hold_addr_o, 32'h110);
    tick; cyc(1, 32'h110, 32'h0, 1, 0);
    chk("fill_fh_full", {31'h0, fetch_hold_o}, 32'h1);
    chk_out("fill_head", 1, 32'h100, mk(32'h100));
    tick; cyc(1, 32'h110, 32'h0, 0, 0);
    chk("fill_fh_rel", {31'h0, fetch_hold_o}, 32'h1);
    chk_out("fill_o0", 1, 32'h100, mk(32'h100));
    tick; cyc(1, 32'h110, 32'h0, 0, 0);
    chk("fill_fh_drop", {31'h0, fetch_hold_o}, 32'h0);
    chk_out("fill_o1", 1, 32'h104, mk(32'h104));
    tick; cyc(0, 32'h0, mk(32'h110), 0, 0); chk_out("fill_o2", 1, 32'h108, mk(32'h108));
    tick; cyc(0, 32'h0, 32'h0, 0, 0);       chk_out("fill_o3", 1, 32'h10C, mk(32'h10C));
    tick; cyc(0, 32'h0, 32'h0, 0, 0);       chk_out("fill_o4", 1, 32'h110, mk(32'h110));
    tick; cyc(0, 32'h0, 32'h0, 0, 0);       chk_out("fill_end", 0, 32'h0, NOP);

    // jump flush with three buffered plus one in flight
    tick; cyc(1, 32'h200, 32'h0, 1, 0);
    tick; cyc(1, 32'h204, mk(32'h200), 1, 0);
    tick; cyc(1, 32'h208, mk(32'h204), 1, 0);
    tick; cyc(1, 32'h20C, mk(32'h208), 1, 0);
    chk("jmp_fh_pre", {31'h0, fetch_hold_o}, 32'h0);
    tick; cyc(1, 32'h20, mk(32'h20C), 1, 1);
    chk("jmp_fh_during", {31'h0, fetch_hold_o}, 32'h0);
    chk_out("jmp_head_pre", 1, 32'h200, mk(32'h200));
    tick; cyc(1, 32'h80, 32'h0, 0, 0);
    chk_out("jmp_after", 0, 32'h0, NOP);
    chk("jmp_fh_after", {31'h0, fetch_hold_o}, 32'h0);
    tick; cyc(0, 32'h0, mk(32'h80), 0, 0); chk_out("jmp_lat", 0, 32'h0, NOP);
    tick; cyc(0, 32'h0, 32'h0, 0, 0);      chk_out("jmp_new", 1, 32'h80, mk(32'h80));
    tick; cyc(0, 32'h0, 32'h0, 0, 0);      chk_out("jmp_end", 0, 32'h0, NOP);

    // wrap: 12 fetches, stall toggled every 3 cycles; fetch_hold pattern hand-derived
    n_acc    = 0;
    n_pop    = 0;
    last_acc = 1'b0;
    last_pc  = 32'h0;
    for (int c = 0; c < 27; c++) begin
      tick;
      hold = ((c / 3) % 2) == 1;
      re   = (n_acc < 12);
      pc   = 32'h300 + 32'(4 * n_acc);
      fh   = (c inside {5, 6, 10, 11, 12, 16, 17, 18});
      cyc(re, pc, last_acc ? mk(last_pc) : 32'h0, hold, 0);
      chk("wrap_fh", {31'h0, fetch_hold_o}, {31'h0, fh});
      if (!hold) begin
        if (c == 0 || c == 1 || c == 26) begin
          chk("wrap_idle", {31'h0, inst_valid_o}, 32'h0);
        end else begin
          chk_out("wrap_pop", 1, 32'h300 + 32'(4 * n_pop), mk(32'h300 + 32'(4 * n_pop)));
          n_pop++;
        end
      end
      last_acc = re && !fh;
      last_pc  = pc;
      if (last_acc) n_acc++;
    end

    // reset with two buffered plus one in flight
    tick; cyc(1, 32'h400, 32'h0, 1, 0);
    tick; cyc(1, 32'h404, mk(32'h400), 1, 0);
    tick; cyc(1, 32'h408, mk(32'h404), 1, 0);
    tick; rst = 1'b1; cyc(0, 32'h0, mk(32'h408), 1, 0);
    chk_out("mrst_pre", 1, 32'h400, mk(32'h400));
    tick; rst = 1'b0; cyc(1, 32'h0, 32'h0, 0, 0);
    chk_out("mrst_after", 0, 32'h0, NOP);
    chk("mrst_fh", {31'h0, fetch_hold_o}, 32'h0);
    tick; cyc(0, 32'h0, mk(32'h0), 0, 0); chk_out("mrst_lat", 0, 32'h0, NOP);
    tick; cyc(0, 32'h0, 32'h0, 0, 0);     chk_out("mrst_new", 1, 32'h0, mk(32'h0));
    tick; cyc(0, 32'h0, 32'h0, 0, 0);     chk_out("mrst_end", 0, 32'h0, NOP);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_fetch_buf.md
INST_FETCH_BUF -- requirements
Module: inst_fetch_buf

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4: number of buffered instruction entries; legal values are powers of two, 2..16.
REQ-002 The block SHALL have parameter NOP_INST, default 32'h00000013: instruction driven when no entry is valid.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 pc_i  input  32  fetch address issued by the PC stage this cycle.
REQ-006 re_i  input  1  fetch issued this cycle; instruction SRAM data returns one cycle later.
REQ-007 inst_i  input  32  instruction SRAM read data for the fetch issued in the previous cycle.
REQ-008 jump_flag_i  input  1  execute-stage redirect; flushes all wrong-path state.
REQ-009 hold_flag_i  input  1  decode stall; head entry is not consumed.
REQ-010 fetch_hold_o  output  1  request to the PC stage to hold and reissue hold_addr_o.
REQ-011 hold_addr_o  output  32  address the PC stage must reissue while fetch_hold_o is high.
REQ-012 inst_o  output  32  head instruction to decode.
REQ-013 inst_addr_o  output  32  address of inst_o.
REQ-014 inst_valid_o  output  1  inst_o/inst_addr_o hold a valid entry.

Function
REQ-015 An in-flight stage SHALL consist of pend_valid and pend_addr; the fetch accept condition SHALL be: re_i=1, fetch_hold_o=0, jump_flag_i=0.
REQ-016 On a fetch accept, the in-flight stage SHALL load pend_addr<=pc_i and pend_valid<=1 at the edge; otherwise pend_valid<=0.
REQ-017 When pend_valid=1 and jump_flag_i=0, the entry {pend_addr, inst_i} SHALL be pushed into the buffer at that edge.
REQ-018 Latency SHALL be: fetch accepted in cycle N, inst_i sampled in cycle N+1, entry visible on the outputs in cycle N+2 if the buffer was empty.
REQ-019 The buffer SHALL be a circular FIFO with DEPTH entries, read/write pointers of log2(DEPTH) bits wrapping modulo DEPTH, and count of log2(DEPTH)+1 bits ranging 0..DEPTH.
REQ-020 inst_valid_o SHALL equal (count!=0); inst_o/inst_addr_o SHALL be the head entry when valid, else NOP_INST/32'h0.
REQ-021 A pop SHALL occur when inst_valid_o=1, hold_flag_i=0 and jump_flag_i=0.
REQ-022 A simultaneous push and pop SHALL leave count unchanged and advance both pointers, including at count=DEPTH and count=1.
REQ-023 fetch_hold_o SHALL be combinational, equal to (count + pend_valid) >= DEPTH, and SHALL be 0 during jump_flag_i=1.
REQ-024 hold_addr_o SHALL equal pc_i; a fetch offered while fetch_hold_o=1 SHALL be discarded, with no state change.
REQ-025 Because of REQ-023/024, a push into a full buffer SHALL be unreachable; an implementation assertion SHALL flag it.
REQ-026 jump_flag_i=1 SHALL, at that edge, clear count, both pointers and pend_valid, suppress the push of inst_i, and discard re_i of the same cycle (wrong-path address).
REQ-027 Priority SHALL be: rst > jump_flag_i > hold_flag_i/fetch_hold_o > normal push/pop.
REQ-028 With hold_flag_i=1, entries SHALL keep arriving until count+pend_valid reaches DEPTH; none SHALL be lost or duplicated.

Reset
REQ-029 With rst=1 at an edge, count, pointers and pend_valid SHALL be 0; any in-flight fetch SHALL be dropped, also when reset occurs mid-operation.
REQ-030 In the cycle after reset: inst_valid_o=0, inst_o=NOP_INST, inst_addr_o=0, fetch_hold_o=0.
REQ-031 Buffer data storage SHALL need no reset.

Verification
REQ-032 Streaming: re_i=1 at pc 0x0,0x4,0x8, inst_i=0xA,0xB,0xC one cycle later, hold=0 -> inst_valid_o from cycle 2; outputs (0x0,0xA),(0x4,0xB),(0x8,0xC) on consecutive cycles.
REQ-033 Fill: hold_flag_i=1 and continuous fetches from 0x100 -> count reaches 4; fetch_hold_o=1 with hold_addr_o=0x110; release hold -> outputs 0x100,0x104,0x108,0x10C then 0x110, with no gap or duplicate.
REQ-034 Jump flush: 3 entries buffered plus one in flight; jump_flag_i=1 with pc_i=0x20 -> next cycle inst_valid_o=0 and inst_o=0x00000013; a following fetch of 0x80 -> head inst_addr_o=0x80.
REQ-035 Wrap and simultaneous push/pop: stream 12 fetches with hold toggled every 3 cycles -> all 12 addresses emitted in order; pointers wrap at least twice; count never exceeds 4.
REQ-036 Reset mid-operation: 2 entries buffered plus one in flight, rst=1 for one cycle -> inst_valid_o=0 and fetch_hold_o=0 next cycle; a fetch of 0x0 then appears after the 2-cycle latency.
